manchester_spi_rx: RTL and testbench

- Receive end of the team's 3-wire serial link: data line, enable line and shared clock. The far-end transmitter serialises each byte LSB-first, two clock cycles per bit.
- The block samples the data line on the shared clk, decodes each two-cycle bit cell and reassembles DATA_W-bit words.
- Each good word is presented with a one-cycle valid strobe. Line-code violations and truncated frames are flagged.
- Sits between the link pins and the hash-table input logic.

---
 rtl/manchester_spi_rx_if.sv | 26 ++
 rtl/manchester_spi_rx.sv | 133 +++++++++++++
 tb/tb_manchester_spi_rx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/manchester_spi_rx_if.sv
// Link-side bundle for the Manchester serial receiver: the two line inputs
// plus the decoded word, status pulses and counters.
interface manchester_spi_rx_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              din;
  logic              en_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              code_err;
  logic              frame_err;
  logic              busy;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output din, en_in,
    input  data_out, data_valid, code_err, frame_err, busy, word_cnt, err_cnt
  );

  modport slave (
    input  din, en_in,
    output data_out, data_valid, code_err, frame_err, busy, word_cnt, err_cnt
  );
endinterface

// File: rtl/manchester_spi_rx.sv
// Manchester bit-cell decoder: two clk cycles per bit (1 = 10, 0 = 01), LSB first,
// reassembled into DATA_W-bit words with violation/truncation flags and counters.
module manchester_spi_rx #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input logic                clk,
  input logic                rst,
  manchester_spi_rx_if.slave link
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, HALF_A, HALF_B, HUNT} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              half_a_q, half_a_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              code_err_q, code_err_d;
  logic              frame_err_q, frame_err_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    half_a_d     = half_a_q;
    word_d       = word_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    code_err_d   = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (link.en_in) begin
          half_a_d = link.din;
          idx_d    = '0;
          state_d  = HALF_B;
        end
      end

      // Index 0 here means the previous word just completed, so a drop is a clean end.
      HALF_A: begin
        if (link.en_in) begin
          half_a_d = link.din;
          state_d  = HALF_B;
        end else begin
          frame_err_d = (idx_q != '0);
          state_d     = IDLE;
        end
      end

      HALF_B: begin
        if (!link.en_in) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (half_a_q == link.din) begin
          code_err_d = 1'b1;
          state_d    = HUNT;
        end else begin
          word_d[idx_q] = half_a_q;
          state_d       = HALF_A;
          if (idx_q == LAST_IDX) begin
            data_valid_d = 1'b1;
            data_out_d   = word_d;
            idx_d        = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      HUNT: begin
        if (!link.en_in) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    word_cnt_d = word_cnt_q;
    if (data_valid_d && (word_cnt_q != '1)) begin
      word_cnt_d = word_cnt_q + 1'b1;
    end

    err_cnt_d = err_cnt_q;
    if ((code_err_d || frame_err_d) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      half_a_q     <= 1'b0;
      word_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      code_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      word_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      half_a_q     <= half_a_d;
      word_q       <= word_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      code_err_q   <= code_err_d;
      frame_err_q  <= frame_err_d;
      word_cnt_q   <= word_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign link.data_out   = data_out_q;
  assign link.data_valid = data_valid_q;
  assign link.code_err   = code_err_q;
  assign link.frame_err  = frame_err_q;
  assign link.word_cnt   = word_cnt_q;
  assign link.err_cnt    = err_cnt_q;
  assign link.busy       = (state_q == HALF_B) || (state_q == HUNT) ||
                           ((state_q == HALF_A) && (idx_q != '0));

endmodule

// File: tb/tb_manchester_spi_rx.sv
// Randomised bench for manchester_spi_rx: frames are built as a cycle timeline whose
// expected pulses come from the frame shape; two DUTs (16-bit and 2-bit counters) share the line.
module tb_manchester_spi_rx;

  localparam int DATA_W = 8;

  typedef struct {
    bit         rst_n;
    bit         en;
    bit         din;
    bit         v;
    bit         ce;
    bit         fe;
    bit         busy;
    logic [7:0] w;
  } cyc_t;

  logic clk;
  logic rst;

  manchester_spi_rx_if #(.DATA_W(DATA_W), .CNT_W(16)) link  ();
  manchester_spi_rx_if #(.DATA_W(DATA_W), .CNT_W(2))  link2 ();

  manchester_spi_rx #(.DATA_W(DATA_W), .CNT_W(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (link)
  );

  manchester_spi_rx #(.DATA_W(DATA_W), .CNT_W(2)) dut_sat (
    .clk  (clk),
    .rst  (rst),
    .link (link2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cyc_t       tl[$];
  int         checks = 0;
  int         fails  = 0;
  int         cyc_no = 0;
  int         n_words = 0;
  int         n_errs  = 0;
  logic [7:0] last_good = '0;

  function automatic void pushCyc(bit r, bit e, bit d, bit v, bit ce, bit fe, bit b,
                                  logic [7:0] w);
    cyc_t c;
    c.rst_n = r; c.en = e; c.din = d; c.v = v; c.ce = ce; c.fe = fe; c.busy = b; c.w = w;
    tl.push_back(c);
  endfunction

  function automatic void addIdle(int n);
    for (int i = 0; i < n; i++) pushCyc(1, 0, 1'($urandom), 0, 0, 0, 0, 8'h00);
  endfunction

  function automatic void addHunt(int n);
    for (int i = 0; i < n; i++) pushCyc(1, 1, 1'($urandom), 0, 0, 0, 1, 8'h00);
  endfunction

  function automatic void addReset(int n, bit en);
    for (int i = 0; i < n; i++) pushCyc(0, en, 1'($urandom), 0, 0, 0, 0, 8'h00);
  endfunction

  // stop_kind: 1 = en_in drops at cycle stop_cyc of the frame, 2 = reset there.
  function automatic void addWord(logic [7:0] w, int bad_bit, int stop_cyc, int stop_kind);
    bit a, b, last;
    for (int k = 0; k < DATA_W; k++) begin
      a = w[k];
      b = (k == bad_bit) ? a : ~a;
      last = (k == DATA_W - 1);
      if (2 * k == stop_cyc) begin
        if (stop_kind == 2) pushCyc(0, 1, 1'($urandom), 0, 0, 0, 0, 8'h00);
        else                pushCyc(1, 0, 1'($urandom), 0, 0, (k != 0), 0, 8'h00);
        return;
      end
      pushCyc(1, 1, a, 0, 0, 0, 1, 8'h00);
      if (2 * k + 1 == stop_cyc) begin
        if (stop_kind == 2) pushCyc(0, 1, 1'($urandom), 0, 0, 0, 0, 8'h00);
        else                pushCyc(1, 0, 1'($urandom), 0, 0, 1, 0, 8'h00);
        return;
      end
      if (k == bad_bit) begin
        pushCyc(1, 1, b, 0, 1, 0, 1, 8'h00);
        return;
      end
      pushCyc(1, 1, b, last, 0, 0, !last, w);
    end
  endfunction

  function automatic int sat(int n, int w);
    int top;
    top = (1 << w) - 1;
    return (n > top) ? top : n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc_no, obs, exp);
    end
  endtask

  task automatic applyStimulus(input cyc_t c);
    @(negedge clk);
    rst = c.rst_n;
    link.en_in  = c.en;
    link.din    = c.din;
    link2.en_in = c.en;
    link2.din   = c.din;
    @(posedge clk);
    #1;
    if (!c.rst_n) begin
      n_words   = 0;
      n_errs    = 0;
      last_good = '0;
    end else begin
      if (c.v) begin
        last_good = c.w;
        n_words++;
      end
      if (c.ce || c.fe) n_errs++;
    end
    checkOutput("data_valid", 32'(link.data_valid), 32'(c.v));
    checkOutput("code_err",   32'(link.code_err),   32'(c.ce));
    checkOutput("frame_err",  32'(link.frame_err),  32'(c.fe));
    checkOutput("busy",       32'(link.busy),       32'(c.busy));
    checkOutput("data_out",   32'(link.data_out),   32'(last_good));
    checkOutput("word_cnt",   32'(link.word_cnt),   32'(sat(n_words, 16)));
    checkOutput("err_cnt",    32'(link.err_cnt),    32'(sat(n_errs, 16)));
    checkOutput("sat_word_cnt", 32'(link2.word_cnt), 32'(sat(n_words, 2)));
    checkOutput("sat_err_cnt",  32'(link2.err_cnt),  32'(sat(n_errs, 2)));
    checkOutput("sat_data_out", 32'(link2.data_out), 32'(last_good));
    cyc_no++;
  endtask

  initial begin
    rst = 1'b0;
    link.en_in = 1'b0;  link.din = 1'b0;
    link2.en_in = 1'b0; link2.din = 1'b0;

    addReset(3, 0);
    addIdle(2);
    addWord(8'hA5, -1, -1, 0);
    addIdle(3);
    addWord(8'h00, -1, -1, 0);
    addWord(8'hFF, -1, -1, 0);
    addIdle(2);
    addWord(8'($urandom), 3, -1, 0);
    addHunt(10);
    addIdle(2);
    addWord(8'h3C, -1, -1, 0);
    addIdle(1);
    addWord(8'($urandom), -1, 8, 1);
    addIdle(2);
    addWord(8'($urandom), -1, 10, 2);
    addIdle(2);
    addWord(8'h81, -1, -1, 0);
    addIdle(2);
    for (int i = 0; i < 5; i++) addWord(8'($urandom), -1, -1, 0);
    addIdle(2);
    addWord(8'($urandom), 7, -1, 0);
    addHunt(2);
    addIdle(1);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: begin
          addWord(8'($urandom), -1, -1, 0);
          if ($urandom_range(0, 1) == 1) addIdle($urandom_range(1, 3));
        end
        1: begin
          addWord(8'($urandom), $urandom_range(0, 7), -1, 0);
          addHunt($urandom_range(0, 4));
          addIdle($urandom_range(1, 3));
        end
        2: begin
          addWord(8'($urandom), -1, $urandom_range(1, 15), 1);
          addIdle($urandom_range(1, 2));
        end
        3: begin
          addWord(8'($urandom), -1, $urandom_range(0, 15), 2);
          addIdle($urandom_range(1, 2));
        end
        default: addIdle($urandom_range(1, 4));
      endcase
    end
    addIdle(3);

    foreach (tl[i]) applyStimulus(tl[i]);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
